// File: rtl/neuron_layer_pkg.sv
// Shared types and helpers for the neuron layer sequencer: FSM states,
// register-file slot geometry, config address decode and watchdog limit.
package neuron_layer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

  typedef struct packed {
    logic [15:0] neuron;
    logic [15:0] slot;
  } cfg_loc_t;

  // Each neuron owns NUM_INPUTS weight slots followed by one bias slot.
  function automatic int slots_f(input int num_inputs);
    return num_inputs + 1;
  endfunction

  function automatic cfg_loc_t decode_addr(input int addr, input int slots);
    cfg_loc_t loc;
    loc.neuron = 16'(addr / slots);
    loc.slot   = 16'(addr % slots);
    return loc;
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_regfile.sv
// Per-neuron weight/bias storage: one synchronous write port, combinational
// read of the selected neuron's full weight vector and bias (zero latency).
module neuron_param_regfile
  import neuron_layer_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 2,
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int IDX_W       = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_we,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [NUM_INPUTS*WIDTH-1:0] o_weights,
  output logic [WIDTH-1:0]            o_bias
);

  localparam int SLOTS = slots_f(NUM_INPUTS);
  localparam int DEPTH = NUM_NEURONS * SLOTS;

  logic [WIDTH-1:0] r_mem [NUM_NEURONS][SLOTS];
  cfg_loc_t         w_loc;
  logic             w_in_range;

  always_comb begin
    w_loc      = decode_addr(int'(i_addr), SLOTS);
    w_in_range = (int'(i_addr) < DEPTH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int s = 0; s < SLOTS; s++) begin
          r_mem[n][s] <= '0;
        end
      end
    end else if (i_we && w_in_range) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int s = 0; s < SLOTS; s++) begin
          if ((w_loc.neuron == 16'(n)) && (w_loc.slot == 16'(s))) begin
            r_mem[n][s] <= i_wdata;
          end
        end
      end
    end
  end

  always_comb begin
    o_weights = '0;
    o_bias    = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (i_rd_idx == IDX_W'(n)) begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          o_weights[k*WIDTH +: WIDTH] = r_mem[n][k];
        end
        o_bias = r_mem[n][NUM_INPUTS];
      end
    end
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one serial neuron datapath over NUM_NEURONS neurons; inputs are fed only on NRN_READY,
// results wait for NRN_VALID_OUT. Optional abort watchdog: NEURON_LAYER_SEQUENCER_WATCHDOG_EN.
module neuron_layer_sequencer
  import neuron_layer_pkg::*;
#(
  parameter int  NUM_NEURONS = 4,
  parameter int  NUM_INPUTS  = 2,
  parameter int  WIDTH       = 8,
  localparam int SLOTS       = slots_f(NUM_INPUTS),
  localparam int ADDR_W      = $clog2(NUM_NEURONS * SLOTS)
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_cfg_we,
  input  logic [ADDR_W-1:0]            i_cfg_addr,
  input  logic [WIDTH-1:0]             i_cfg_wdata,
  input  logic                         i_start,
  input  logic [NUM_INPUTS*WIDTH-1:0]  i_in_vector,
  output logic                         o_busy,
  output logic                         o_out_valid,
  output logic [NUM_NEURONS*WIDTH-1:0] o_out_vector,
  output logic                         o_nrn_clr,
  output logic [NUM_INPUTS*WIDTH-1:0]  o_nrn_weights,
  output logic [WIDTH-1:0]             o_nrn_bias,
  output logic [WIDTH-1:0]             o_nrn_value_in,
  output logic                         o_nrn_valid_in,
  input  logic                         i_nrn_ready,
  input  logic [WIDTH-1:0]             i_nrn_value_out,
  input  logic                         i_nrn_valid_out
`ifdef NEURON_LAYER_SEQUENCER_WATCHDOG_EN
  ,
  output logic                         o_timeout
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int K_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_N = IDX_W'(NUM_NEURONS - 1);
  localparam logic [K_W-1:0]   LAST_K = K_W'(NUM_INPUTS - 1);

  state_t                       r_state;
  logic [IDX_W-1:0]             r_n;
  logic [K_W-1:0]               r_k;
  logic [NUM_INPUTS*WIDTH-1:0]  r_in_vec;
  logic [NUM_NEURONS*WIDTH-1:0] r_out_vec;
  logic                         r_busy;
  logic                         r_out_valid;
  logic                         r_nrn_clr;

  logic                         w_cfg_we;
  logic                         w_strobe;
  logic [WIDTH-1:0]             w_value_in;

  // Config is frozen for the whole run, including the DONE cycle.
  assign w_cfg_we = i_cfg_we && (r_state == S_IDLE);
  assign w_strobe = (r_state == S_FEED) && i_nrn_ready;

  neuron_param_regfile #(
    .NUM_NEURONS (NUM_NEURONS),
    .NUM_INPUTS  (NUM_INPUTS),
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_we      (w_cfg_we),
    .i_addr    (i_cfg_addr),
    .i_wdata   (i_cfg_wdata),
    .i_rd_idx  (r_n),
    .o_weights (o_nrn_weights),
    .o_bias    (o_nrn_bias)
  );

  always_comb begin
    w_value_in = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (r_k == K_W'(k)) begin
        w_value_in = r_in_vec[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef NEURON_LAYER_SEQUENCER_WATCHDOG_EN
  logic [15:0] r_wdog;
  logic        r_timeout;
  logic        w_wdog_active;
  logic        w_leave;
  logic        w_wdog_fire;

  assign w_wdog_active = (r_state == S_FEED) || (r_state == S_WAIT);
  assign w_leave       = (w_strobe && (r_k == LAST_K)) ||
                         ((r_state == S_WAIT) && i_nrn_valid_out);
  // Abort on the edge where the count would reach the limit, so the pulse lands
  // exactly WDOG_LIMIT cycles after the state was entered.
  assign w_wdog_fire   = w_wdog_active && !w_leave && (r_wdog == WDOG_LIMIT - 16'd1);
  assign o_timeout     = r_timeout;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_k         <= '0;
      r_in_vec    <= '0;
      r_out_vec   <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_nrn_clr   <= 1'b0;
`ifdef NEURON_LAYER_SEQUENCER_WATCHDOG_EN
      r_wdog      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_nrn_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_in_vec  <= i_in_vector;
            r_n       <= '0;
            r_busy    <= 1'b1;
            r_nrn_clr <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_k     <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (w_strobe) begin
            if (r_k == LAST_K) begin
              r_state <= S_WAIT;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (i_nrn_valid_out) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
              if (r_n == IDX_W'(n)) begin
                r_out_vec[n*WIDTH +: WIDTH] <= i_nrn_value_out;
              end
            end
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_n == LAST_N) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_n       <= r_n + 1'b1;
            r_nrn_clr <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
`ifdef NEURON_LAYER_SEQUENCER_WATCHDOG_EN
      r_timeout <= 1'b0;
      r_wdog    <= '0;
      if (w_wdog_fire) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_nrn_clr <= 1'b1;
        r_timeout <= 1'b1;
      end else if (w_wdog_active && !w_leave) begin
        r_wdog <= r_wdog + 16'd1;
      end
`endif
    end
  end

  assign o_busy         = r_busy;
  assign o_out_valid    = r_out_valid;
  assign o_out_vector   = r_out_vec;
  assign o_nrn_clr      = r_nrn_clr;
  assign o_nrn_value_in = w_value_in;
  assign o_nrn_valid_in = w_strobe;

endmodule
